// File: rtl/branch_resolve_unit.sv
// Execute-stage conditional-branch resolver with a single registered result stage,
// valid/ready handshake, flush kill and saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam logic [2:0] F_BEQ  = 3'b000;
  localparam logic [2:0] F_BNE  = 3'b001;
  localparam logic [2:0] F_BLT  = 3'b100;
  localparam logic [2:0] F_BGE  = 3'b101;
  localparam logic [2:0] F_BLTU = 3'b110;
  localparam logic [2:0] F_BGEU = 3'b111;

  logic            eq, gtu, gts, lts, ltu;
  logic            cond_taken, cond_illegal, cond_mp;
  logic [XLEN-1:0] cond_target, cond_redirect;
  logic            accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Signed compare: differing sign bits decide outright, otherwise the magnitudes do.
  assign eq  = (rs1 == rs2);
  assign gtu = (rs1 > rs2);
  assign gts = (rs1[XLEN-1] != rs2[XLEN-1]) ? rs2[XLEN-1]
                                             : (rs1[XLEN-2:0] > rs2[XLEN-2:0]);
  assign lts = !gts && !eq;
  assign ltu = !gtu && !eq;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (funct3)
      F_BEQ:   cond_taken = eq;
      F_BNE:   cond_taken = !eq;
      F_BLT:   cond_taken = lts;
      F_BGE:   cond_taken = !lts;
      F_BLTU:  cond_taken = ltu;
      F_BGEU:  cond_taken = !ltu;
      default: cond_illegal = 1'b1;
    endcase
  end

  assign cond_mp       = cond_taken ^ pred_taken;
  assign cond_target   = pc + imm;
  assign cond_redirect = cond_taken ? cond_target : (pc + XLEN'(4));

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      taken       <= 1'b0;
      target      <= '0;
      redirect_pc <= '0;
      mispredict  <= 1'b0;
      illegal     <= 1'b0;
      br_count    <= '0;
      mp_count    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      taken       <= cond_taken;
      target      <= cond_target;
      redirect_pc <= cond_redirect;
      mispredict  <= cond_mp;
      illegal     <= cond_illegal;
      if (!cond_illegal && (br_count != '1)) br_count <= br_count + CNT_W'(1);
      if (cond_mp && (mp_count != '1))       mp_count <= mp_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural model of the branch rules.
module tb_branch_resolve_unit;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             pred_taken = 1'b0;
  logic [2:0]       funct3 = 3'b000;
  logic [XLEN-1:0]  rs1 = '0, rs2 = '0, pc = '0, imm = '0;
  logic             in_ready, out_valid, taken, mispredict, illegal;
  logic [XLEN-1:0]  target, redirect_pc;
  logic [CNT_W-1:0] br_count, mp_count;

  int checks = 0;
  int failures = 0;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .redirect_pc(redirect_pc), .mispredict(mispredict), .illegal(illegal),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: branch semantics straight from the ISA rules using native signed/unsigned compares.
  function automatic logic [1:0] eval_branch(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic t, ill;
    t = 1'b0;
    ill = 1'b0;
    case (f)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = ($signed(a) <  $signed(b));
      3'd5:    t = ($signed(a) >= $signed(b));
      3'd6:    t = (a <  b);
      3'd7:    t = (a >= b);
      default: ill = 1'b1;
    endcase
    return {ill, t};
  endfunction

  bit          m_valid = 1'b0;
  logic        m_taken = 1'b0, m_mp = 1'b0, m_ill = 1'b0;
  logic [31:0] m_target = '0, m_redir = '0;
  int          m_br = 0, m_mpc = 0;
  bit          m_rdy;
  logic [1:0]  m_res;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_valid = 1'b0; m_taken = 1'b0; m_mp = 1'b0; m_ill = 1'b0;
      m_target = '0; m_redir = '0; m_br = 0; m_mpc = 0;
    end else begin
      m_rdy = !m_valid || out_ready;
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && m_rdy) begin
        m_res    = eval_branch(funct3, rs1, rs2);
        m_valid  = 1'b1;
        m_ill    = m_res[1];
        m_taken  = m_res[0];
        m_mp     = m_res[0] != pred_taken;
        m_target = pc + imm;
        m_redir  = m_taken ? m_target : pc + 32'd4;
        if (!m_ill && m_br < CMAX) m_br++;
        if (m_mp && m_mpc < CMAX)  m_mpc++;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("m_out_valid", out_valid, m_valid);
    check("m_in_ready", in_ready, !m_valid || out_ready);
    check("m_br_count", br_count, m_br);
    check("m_mp_count", mp_count, m_mpc);
    if (m_valid || rst) begin
      check("m_taken", taken, m_taken);
      check("m_target", target, m_target);
      check("m_redirect", redirect_pc, m_redir);
      check("m_mispredict", mispredict, m_mp);
      check("m_illegal", illegal, m_ill);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pt);
    funct3 = f; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt; in_valid = 1'b1;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0; flush = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1 rst = 1'b1;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_br_count", br_count, 0);
    check("rst_target", target, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", in_ready, 1);

    out_ready = 1'b1;
    drive(3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'hFFFFFFF0, 1'b0);
    step();
    in_valid = 1'b0;
    check("eq_taken", taken, 1);
    check("eq_target", target, 32'hF0);
    check("eq_redirect", redirect_pc, 32'hF0);
    check("eq_mispredict", mispredict, 1);
    check("eq_mp_count", mp_count, 1);
    check("eq_br_count", br_count, 1);

    drive(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8, 1'b1);
    step();
    check("blt_taken", taken, 1);
    check("blt_mispredict", mispredict, 0);
    drive(3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8, 1'b1);
    step();
    check("bltu_taken", taken, 0);
    drive(3'b101, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8, 1'b0);
    step();
    check("bge_taken", taken, 0);

    drive(3'b001, 32'h5, 32'h5, 32'hFFFFFFFC, 32'h8, 1'b1);
    step();
    in_valid = 1'b0;
    check("wrap_taken", taken, 0);
    check("wrap_redirect", redirect_pc, 32'h0);
    check("wrap_mispredict", mispredict, 1);
    step();

    reset_dut();
    out_ready = 1'b0;
    drive(3'b000, 32'h1, 32'h1, 32'h1000, 32'h0, 1'b1);
    step();
    check("bp_valid1", out_valid, 1);
    check("bp_in_ready", in_ready, 0);
    drive(3'b000, 32'h1, 32'h1, 32'h2000, 32'h0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_target", target, 32'h1000);
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", in_ready, 1);
    step();
    check("bp_pkt2", target, 32'h2000);
    drive(3'b000, 32'h1, 32'h1, 32'h3000, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_pkt3", target, 32'h3000);
    check("bp_br_count", br_count, 3);
    step();
    check("bp_drained", out_valid, 0);

    reset_dut();
    out_ready = 1'b0;
    drive(3'b000, 32'h1, 32'h1, 32'h4000, 32'h0, 1'b1);
    step();
    check("fl_held", out_valid, 1);
    drive(3'b000, 32'h1, 32'h1, 32'h5000, 32'h0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_br_count", br_count, 1);
    step();
    check("fl_still_empty", out_valid, 0);

    out_ready = 1'b1;
    drive(3'b011, 32'h1, 32'h2, 32'h600, 32'h10, 1'b0);
    step();
    in_valid = 1'b0;
    check("ill_illegal", illegal, 1);
    check("ill_taken", taken, 0);
    check("ill_redirect", redirect_pc, 32'h604);
    check("ill_br_count", br_count, 1);
    check("ill_mp_count", mp_count, 0);
    step();

    reset_dut();
    drive(3'b000, 32'h7, 32'h7, 32'h0, 32'h4, 1'b0);
    repeat (65536) step();
    check("sat_mp_count", mp_count, 32'hFFFF);
    check("sat_br_count", br_count, 32'hFFFF);
    step();
    check("sat_mp_hold", mp_count, 32'hFFFF);
    in_valid = 1'b0;
    step();

    reset_dut();
    repeat (3000) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      funct3     = 3'($urandom);
      rs1        = a;
      rs2        = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 3) == 0) ? ~a : $urandom);
      pc         = $urandom;
      imm        = $urandom;
      pred_taken = 1'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
